sample_tx_packer: RTL and testbench

Downstream stage of the filter control block: captures each 16-bit filter output sample on a valid strobe, buffers it in a small FIFO, and serializes it into the UART transmit FIFO as two bytes, high byte first. Honours `tx_full` backpressure and never splits or reorders a sample's byte pair. Overflow is flagged rather than silently hidden.

---
 rtl/sample_tx_packer.sv | 145 ++++++++++++++
 tb/tb_sample_tx_packer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_tx_packer.sv
// Buffers 16-bit filter samples in a small FIFO and streams each one
// to the UART TX FIFO as a high/low byte pair.
module sample_tx_packer #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    input  logic [15:0]           s_data,
    input  logic                  flush,
    input  logic                  tx_full,
    output logic                  wr_uart,
    output logic [7:0]            w_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  ovf,
    output logic                  busy
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        HI,
        LO
    } state_t;

    state_t                  state;
    logic [15:0]             hold;
    logic [15:0]             mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wptr;
    logic [DEPTH_LOG2-1:0]   rptr;

    logic has_data;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign has_data = (count != '0);
    assign full     = (count == FULL_CNT);

    // A pop frees a slot, so a push into a full FIFO still lands that cycle
    always_comb begin
        pop = 1'b0;
        case (state)
            IDLE:    pop = has_data;
            LO:      pop = has_data & ~tx_full;
            default: pop = 1'b0;
        endcase
        pop  = pop & ~flush;
        push = s_valid & ~flush & (~full | pop);
        drop = s_valid & ~flush & full & ~pop;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

    // A sample already in flight always finishes, even across a flush
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            hold  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        hold  <= mem[rptr];
                        state <= HI;
                    end
                end
                HI: begin
                    if (!tx_full) begin
                        state <= LO;
                    end
                end
                LO: begin
                    if (!tx_full) begin
                        if (pop) begin
                            hold  <= mem[rptr];
                            state <= HI;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        wr_uart = 1'b0;
        w_data  = 8'h00;
        case (state)
            HI: begin
                wr_uart = ~tx_full;
                w_data  = hold[15:8];
            end
            LO: begin
                wr_uart = ~tx_full;
                w_data  = hold[7:0];
            end
            default: begin
                wr_uart = 1'b0;
                w_data  = 8'h00;
            end
        endcase
    end

    assign busy = (state != IDLE) | has_data;

endmodule

// File: tb/tb_sample_tx_packer.sv
// Bench for sample_tx_packer: directed scenarios plus random traffic,
// checked every cycle against a queue-based byte-stream model.
module tb_sample_tx_packer;

    localparam int DL2   = 3;
    localparam int DEPTH = 2 ** DL2;

    logic           clk = 1'b0;
    logic           reset;
    logic           s_valid;
    logic [15:0]    s_data;
    logic           flush;
    logic           tx_full;
    logic           wr_uart;
    logic [7:0]     w_data;
    logic [DL2:0]   count;
    logic           ovf;
    logic           busy;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mq [$];
    logic [7:0]  oq [$];
    logic [7:0]  got [$];
    logic [7:0]  exp_b [$];
    bit          m_ovf;

    sample_tx_packer #(.DEPTH_LOG2(DL2)) dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_data  (s_data),
        .flush   (flush),
        .tx_full (tx_full),
        .wr_uart (wr_uart),
        .w_data  (w_data),
        .count   (count),
        .ovf     (ovf),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bytes(input string tag, input logic [7:0] e [$]);
        chk({tag, "_len"}, got.size(), e.size());
        for (int i = 0; i < e.size(); i++) begin
            chk($sformatf("%s_b%0d", tag, i), got[i], e[i]);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        oq.delete();
        m_ovf = 1'b0;
    endtask

    // One clock cycle: drive, compare outputs with the model, advance model
    task automatic step(input bit sv, input logic [15:0] sd,
                        input bit fl, input bit tf);
        bit          e_wr;
        logic [7:0]  e_wd;
        bit          pop;
        bit          full;
        logic [15:0] h;
        s_valid = sv;
        s_data  = sd;
        flush   = fl;
        tx_full = tf;
        #3;
        e_wr = (oq.size() > 0) && !tf;
        e_wd = (oq.size() > 0) ? oq[0] : 8'h00;
        chk("wr_uart", wr_uart, e_wr);
        chk("w_data", w_data, e_wd);
        chk("count", count, mq.size());
        chk("ovf", ovf, m_ovf);
        chk("busy", busy, (oq.size() > 0) || (mq.size() > 0));
        if (wr_uart) got.push_back(w_data);
        full = (mq.size() == DEPTH);
        pop  = !fl && (mq.size() > 0) &&
               (oq.size() == 0 || (oq.size() == 1 && !tf));
        if (e_wr) void'(oq.pop_front());
        if (pop) begin
            h = mq.pop_front();
            oq.push_back(h[15:8]);
            oq.push_back(h[7:0]);
        end
        if (fl) begin
            mq.delete();
            m_ovf = 1'b0;
        end else if (sv) begin
            if (!full || pop) mq.push_back(sd);
            else m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((mq.size() > 0 || oq.size() > 0) && k < 100) begin
            step(1'b0, 16'h0, 1'b0, 1'b0);
            k++;
        end
        chk("drain_timeout", mq.size() + oq.size(), 0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    initial begin
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = 16'h0;
        flush   = 1'b0;
        tx_full = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr", wr_uart, 0);
        chk("rst_wd", w_data, 0);
        reset = 1'b0;
        step(1'b0, 16'h0, 1'b0, 1'b0);

        // Single sample
        got.delete();
        step(1'b1, 16'h1234, 1'b0, 1'b0);
        chk("single_cnt1", count, 1);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        chk("single_hi_wr", wr_uart, 1);
        chk("single_hi_wd", w_data, 8'h12);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        chk("single_lo_wd", w_data, 8'h34);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        chk("single_busy", busy, 0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        exp_b = {8'h12, 8'h34};
        chk_bytes("single", exp_b);

        // Back-to-back samples every two cycles
        got.delete();
        step(1'b1, 16'hA1B2, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b1, 16'hC3D4, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b1, 16'hE5F6, 1'b0, 1'b0);
        drain();
        exp_b = {8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
        chk_bytes("b2b", exp_b);
        chk("b2b_ovf", ovf, 0);

        // Backpressure at the HI byte
        got.delete();
        step(1'b1, 16'h00FF, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        repeat (5) step(1'b0, 16'h0, 1'b0, 1'b1);
        chk("bp_none", got.size(), 0);
        drain();
        exp_b = {8'h00, 8'hFF};
        chk_bytes("bp", exp_b);

        // Overflow while the UART is full
        got.delete();
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 16'(i), 1'b0, 1'b1);
        end
        chk("ovf_count", count, 8);
        chk("ovf_flag", ovf, 1);
        drain();
        exp_b.delete();
        for (int i = 1; i <= 9; i++) begin
            exp_b.push_back(8'h00);
            exp_b.push_back(8'(i));
        end
        chk_bytes("ovf", exp_b);
        chk("ovf_sticky", ovf, 1);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("ovf_flush_clr", ovf, 0);

        // Flush during the LO byte of 0x5566
        got.delete();
        step(1'b1, 16'h5566, 1'b0, 1'b1);
        step(1'b1, 16'h1111, 1'b0, 1'b1);
        step(1'b1, 16'h2222, 1'b0, 1'b1);
        step(1'b1, 16'h3333, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("flush_count", count, 0);
        chk("flush_ovf", ovf, 0);
        repeat (4) step(1'b0, 16'h0, 1'b0, 1'b0);
        exp_b = {8'h55, 8'h66};
        chk_bytes("flush", exp_b);

        // Reset during HI with three samples queued
        got.delete();
        step(1'b1, 16'hABCD, 1'b0, 1'b1);
        step(1'b1, 16'h4444, 1'b0, 1'b1);
        step(1'b1, 16'h5555, 1'b0, 1'b1);
        step(1'b1, 16'h6666, 1'b0, 1'b1);
        chk("pre_rst_count", count, 3);
        s_valid = 1'b0;
        tx_full = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_wr", wr_uart, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        chk("midrst_count", count, 0);
        chk("midrst_ovf", ovf, 0);
        chk("midrst_busy", busy, 0);
        step(1'b1, 16'h7788, 1'b0, 1'b0);
        drain();
        exp_b = {8'h77, 8'h88};
        chk_bytes("midrst", exp_b);

        // Random traffic with bursts of backpressure and rare flushes
        for (int i = 0; i < 1500; i++) begin
            bit sv, fl, tf;
            sv = ($urandom_range(0, 1) == 0);
            fl = ($urandom_range(0, 59) == 0);
            if ((i % 200) < 60) tf = ($urandom_range(0, 9) != 0);
            else tf = ($urandom_range(0, 3) == 0);
            step(sv, 16'($urandom), fl, tf);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
